sk_prefix_adder_pipe: RTL
=========================

SK_PREFIX_ADDER_PIPE -- requirements
Module: sk_prefix_adder_pipe

Interface
REQ-001 Parameter: WIDTH, default 16, operand width; SHALL be a power of two, 4..64.
REQ-002 Parameter: STAGES, default 2, pipeline register stages; SHALL be 1..clog2(WIDTH)+1.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in_valid  input  1  operand beat valid.
REQ-006 Port: in_ready  output  1  block accepts a beat this cycle.
REQ-007 Port: in_a, in_b  input  WIDTH  unsigned operands.
REQ-008 Port: in_cin  input  1  carry-in.
REQ-009 Port: out_valid  output  1  result beat valid.
REQ-010 Port: out_ready  input  1  downstream accepts the result.
REQ-011 Port: out_sum  output  WIDTH  sum bits.
REQ-012 Port: out_cout  output  1  carry-out.

Function
REQ-013 Result SHALL equal {out_cout,out_sum} = in_a + in_b + in_cin, modulo 2^(WIDTH+1).
REQ-014 Carry computation SHALL use a Sklansky prefix network: bitwise g=a&b, p=a^b; clog2(WIDTH) levels; level k combines each bit's (g,p) with the group ending at the top of the preceding 2^k-block; sum = p ^ carry.
REQ-015 in_cin SHALL enter as group generate at position -1, so no post-network increment exists.
REQ-016 Pipeline registers SHALL be distributed across the network as evenly as possible; the last register drives the outputs directly (no combinational path from in_* to out_*).
REQ-017 Global advance = out_ready | ~out_valid; in_ready SHALL equal advance; all stage registers and valid bits load only when advance=1.
REQ-018 A beat transfers on input when in_valid & in_ready, on output when out_valid & out_ready.
REQ-019 Latency with out_ready held high SHALL be exactly STAGES cycles from input transfer to out_valid=1; throughput one beat per cycle.
REQ-020 While out_valid=1 and out_ready=0, out_sum/out_cout/out_valid SHALL hold stable and in_ready SHALL be 0.
REQ-021 Stage valid bits SHALL propagate bubbles; data registers of invalid stages may hold any value, but out_sum/out_cout SHALL be 0 whenever out_valid=0.
REQ-022 Beats SHALL exit in acceptance order; none dropped or duplicated.

Reset
REQ-023 rst=1 SHALL clear every stage valid bit and data register within the same edge; out_valid=0, out_sum=0, out_cout=0 (and out_ovf=0 if present) the cycle after.
REQ-024 In-flight beats at reset SHALL be discarded; in_ready SHALL be 1 during and after reset.
REQ-025 rst SHALL take priority over advance.

Configuration
REQ-026 Macro SK_ADDER_OVF_EN: when defined, add output port out_ovf (1 bit) = signed two's-complement overflow (carry into MSB ^ carry out of MSB), pipelined in lockstep with out_sum; when undefined, the port and its logic SHALL be absent.

Structure
REQ-027 Package sk_pkg SHALL hold the gp_t struct (g,p bits), function sk_levels(width)=clog2(width), and the stage-placement function mapping prefix level to register boundary.
REQ-028 One sub-module sk_prefix_level SHALL implement one combinational Sklansky level, parameterised by WIDTH and level index; the top instantiates it clog2(WIDTH) times.

Verification (WIDTH=16, STAGES=2 unless stated)
REQ-029 a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> after 2 cycles out_sum=0x0000, out_cout=1 (out_ovf=0).
REQ-030 Back-to-back beats a=0x7FFF,b=0x0001,cin=0 then a=0x1234,b=0x4321,cin=1 -> consecutive cycles out_sum=0x8000 (out_ovf=1) then 0x5556, cout=0 both.
REQ-031 Backpressure: three beats in, out_ready=0 for 4 cycles -> out_valid held with first result, in_ready=0, no loss; release -> three results in order.
REQ-032 Reset mid-flight: two beats accepted, rst pulsed one cycle -> out_valid=0, out_sum=0, no stale result ever emerges.
REQ-033 Sweep WIDTH in {4,32,64}, STAGES in {1,clog2(WIDTH)+1}, 10k random beats with random valid/ready -> all results match a+b+cin reference model, latency per REQ-019.

Source files
------------

// File: rtl/sk_pkg.sv
// sk_pkg: shared types and elaboration helpers for the Sklansky prefix adder pipeline
package sk_pkg;
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;
  function automatic int sk_levels(input int width);
    return $clog2(width);
  endfunction
  // true when a pipeline register sits in front of prefix level `level`; the last register is always after the sum
  function automatic logic sk_reg_at(input int level, input int levels, input int stages);
    return ((level + 1) * stages) / (levels + 1) != (level * stages) / (levels + 1);
  endfunction
endpackage

// File: rtl/sk_prefix_level.sv
// sk_prefix_level: one combinational Sklansky level (gp_i -> gp_o) for prefix level LEVEL
module sk_prefix_level
  import sk_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEVEL = 0
) (
  input  gp_t [WIDTH-1:0] gp_i,
  output gp_t [WIDTH-1:0] gp_o
);
  for (genvar i = 0; i < WIDTH; i++) begin : b
    if (((i >> LEVEL) & 1) == 1) begin : c
      localparam int J = ((i >> LEVEL) << LEVEL) - 1;
      assign gp_o[i].g = gp_i[i].g | (gp_i[i].p & gp_i[J].g);
      assign gp_o[i].p = gp_i[i].p & gp_i[J].p;
    end else begin : c
      assign gp_o[i] = gp_i[i];
    end
  end
endmodule

// File: rtl/sk_prefix_adder_pipe.sv
// sk_prefix_adder_pipe: pipelined Sklansky adder {out_cout,out_sum} = in_a + in_b + in_cin with valid/ready
// Ports: in_valid/in_ready/in_a/in_b/in_cin operand beat; out_valid/out_ready/out_sum/out_cout result beat.
// SK_ADDER_OVF_EN adds out_ovf, the signed overflow of the sum.
module sk_prefix_adder_pipe
  import sk_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef SK_ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);
  localparam int LEVELS = sk_levels(WIDTH);
  logic adv;
  assign adv = out_ready | ~out_valid;
  assign in_ready = adv;
  gp_t [WIDTH-1:0] gp_in;
  logic [WIDTH-1:0] p_in;
  assign p_in = in_a ^ in_b;
  // cin is the generate of position -1; folding it into bit 0 leaves no increment after the network
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      gp_in[i].g = in_a[i] & in_b[i];
      gp_in[i].p = p_in[i];
    end
    gp_in[0].g = (in_a[0] & in_b[0]) | (p_in[0] & in_cin);
  end
  for (genvar j = 0; j < LEVELS; j++) begin : st
    gp_t [WIDTH-1:0] gp_d, gp_q, gp_o;
    logic [WIDTH-1:0] p_d, p_q;
    logic cin_d, cin_q, v_d, v_q;
    if (j == 0) begin : src
      assign gp_d = gp_in;
      assign p_d = p_in;
      assign cin_d = in_cin;
      assign v_d = in_valid;
    end else begin : src
      assign gp_d = st[j-1].gp_o;
      assign p_d = st[j-1].p_q;
      assign cin_d = st[j-1].cin_q;
      assign v_d = st[j-1].v_q;
    end
    if (sk_reg_at(j, LEVELS, STAGES)) begin : r
      always_ff @(posedge clk)
        if (rst) begin
          v_q <= 1'b0;
          cin_q <= 1'b0;
          p_q <= '0;
          gp_q <= '0;
        end else if (adv) begin
          v_q <= v_d;
          cin_q <= cin_d;
          p_q <= p_d;
          gp_q <= gp_d;
        end
    end else begin : r
      assign v_q = v_d;
      assign cin_q = cin_d;
      assign p_q = p_d;
      assign gp_q = gp_d;
    end
    sk_prefix_level #(.WIDTH(WIDTH), .LEVEL(j)) u_lvl (.gp_i(gp_q), .gp_o(gp_o));
  end
  logic [WIDTH-1:0] c, unused_pg, sum;
  logic v_l;
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      c[i] = st[LEVELS-1].gp_o[i].g;
      unused_pg[i] = st[LEVELS-1].gp_o[i].p;
    end
  end
  assign v_l = st[LEVELS-1].v_q;
  assign sum = st[LEVELS-1].p_q ^ {c[WIDTH-2:0], st[LEVELS-1].cin_q};
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_sum <= '0;
      out_cout <= 1'b0;
    end else if (adv) begin
      out_valid <= v_l;
      out_sum <= v_l ? sum : '0;
      out_cout <= v_l & c[WIDTH-1];
    end
`ifdef SK_ADDER_OVF_EN
  always_ff @(posedge clk)
    if (rst) out_ovf <= 1'b0;
    else if (adv) out_ovf <= v_l & (c[WIDTH-1] ^ c[WIDTH-2]);
`endif
endmodule
